pic_irq_arbiter: RTL
====================

Name: pic_irq_arbiter

Overview:
- Synchronous priority arbiter and INTA sequencer for the 8259A PIC.
- Shares the single CPU interrupt line among eight IR requesters: samples requests, applies the mask, and resolves fully-nested or rotating priority against the in-service set.
- Runs the two-pulse INTA handshake, then owns the ISR bits and EOI handling.
- Sits between the IRR/IMR registers and the data-bus buffer; replaces ad-hoc edge-triggered flag logic with one clocked FSM.

Parameters:
- NUM_IR, 8, number of interrupt request lines (index width fixed at 3; only 8 is supported).
- SPURIOUS_IDX, 7, index reported when the request vanishes before the first INTA.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ir_req  input  8  level-sensitive interrupt requests, already synchronised to clk.
- imr  input  8  mask; 1 = line masked.
- vector_base  input  5  ICW2[7:3], upper bits of the vector.
- inta_n  input  1  CPU acknowledge, active low, synchronised to clk.
- eoi_valid  input  1  one-cycle EOI command strobe.
- eoi_specific  input  1  1 = specific EOI, 0 = non-specific.
- eoi_level  input  3  target level for specific EOI.
- rotate_on_eoi  input  1  1 = cleared level becomes lowest priority.
- int_out  output  1  interrupt request to CPU.
- vector_out  output  8  {vector_base, index}.
- vector_valid  output  1  high while vector_out must be driven on the bus.
- irr_out  output  8  registered IRR, for OCW3 reads.
- isr_out  output  8  in-service register, for OCW3 reads.
- freeze  output  1  high between the first and second INTA pulses.

Behaviour:
- Reset values:
  - int_out, vector_valid, freeze = 0.
  - vector_out, irr_out, isr_out = 0.
  - Priority pointer lowest_idx = 7, so IR0 has highest priority.
  - FSM in IDLE.
- IRR: irr_out <= ir_req every cycle, except when freeze = 1 (held).
- Priority order is lowest_idx+1, lowest_idx+2, ... mod 8; the last entry is lowest_idx itself.
- Candidate: the highest-priority bit of irr_out & ~imr that is strictly higher priority than the highest-priority isr_out bit. An empty ISR admits any bit.
- Inta falling edge: inta_n_q is inta_n registered; a falling edge is inta_n_q=1 and inta_n=0.
- FSM:
  - IDLE: candidate exists -> REQ, int_out <= 1 (int_out rises 2 cycles after ir_req).
  - REQ, candidate vanishes before INTA: -> IDLE, int_out <= 0.
  - REQ, first falling edge: latch winner index, set its ISR bit, freeze <= 1, -> ACK1.
    - If no candidate at that edge: latch SPURIOUS_IDX, set no ISR bit.
  - ACK1, second falling edge: vector_out <= {vector_base, idx}, vector_valid <= 1, int_out <= 0, freeze <= 0, -> ACK2.
  - ACK2, inta_n high: vector_valid <= 0 -> IDLE.
  - Other falling edges are ignored.
- EOI (any state, one per strobe):
  - Non-specific clears the highest-priority set ISR bit.
  - Specific clears bit eoi_level.
  - With rotate_on_eoi = 1, lowest_idx <= the cleared index.
  - EOI with no matching set bit: no change to ISR or the pointer.
- Same-cycle EOI and first INTA edge: the EOI clear is applied first, then the new ISR bit is set; a cleared bit equal to the new bit ends up set.
- Reset mid-handshake: all state returns to reset values; a following INTA pulse while in IDLE is ignored.

Optional Feature:
- AUTO_EOI_EN
  - Defined: at the second INTA falling edge the ISR bit set at the first edge is cleared automatically.
    - With rotate_on_eoi = 1, lowest_idx <= that index.
    - eoi_valid is still honoured.
  - Undefined: ISR bits clear only through eoi_valid.

Decomposition:
- Package pic_pkg holds:
  - the FSM state enum (IDLE, REQ, ACK1, ACK2);
  - the IDX_W = 3 constant;
  - a rotating-priority find-first function: (vector, lowest_idx) -> {found, index}.
- Sub-module pic_prio_encoder: combinational rotating priority encoder, instantiated twice (request side and ISR side).

Test Plan:
- Reset, imr = 0, ir_req = 8'h24 -> int_out high 2 cycles later; two INTA pulses with vector_base = 5'h10 -> vector_out = 8'h82, isr_out = 8'h04.
- ISR = 8'h04, ir_req adds bit 1 -> int_out asserts (nesting); add bit 5 instead -> int_out stays 0.
- ir_req = 8'h08 withdrawn after int_out, before the first INTA -> int_out drops; if withdrawn between the edge-sample and the first edge -> vector_out = {base, 3'd7}, isr_out unchanged.
- isr_out = 8'h0A, non-specific EOI with rotate_on_eoi = 1 -> isr_out = 8'h08, lowest_idx = 1, IR2 now highest priority.
- EOI strobe in the same cycle as the first INTA edge; and reset_n low in ACK1 -> outputs return to reset values, and the next inta_n pulse produces no vector.
- AUTO_EOI_EN defined, ir_req = 8'h01 -> isr_out = 8'h01 after the first edge and 8'h00 after the second edge.

Source files
------------

// File: rtl/pic_irq_arbiter_pkg.sv
// pic_pkg: shared FSM states, index width and rotating find-first helpers for the PIC arbiter.
package pic_pkg;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_e;
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } prio_t;
  // Scan from lowest+8 down to lowest+1 so the last hit is the highest priority one.
  function automatic prio_t find_first(input logic [7:0] vec, input logic [IDX_W-1:0] lowest);
    prio_t r;
    logic [IDX_W-1:0] i;
    r = '0;
    for (int k = 8; k >= 1; k--) begin
      i = lowest + IDX_W'(k);
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx = i;
      end
    end
    return r;
  endfunction
  function automatic logic [IDX_W-1:0] rank(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] lowest);
    return idx - lowest - IDX_W'(1);
  endfunction
endpackage

// File: rtl/pic_irq_arbiter_if.sv
// pic_irq_arbiter_if: request, acknowledge, EOI and readback signals of the PIC arbiter.
interface pic_irq_arbiter_if;
  logic [7:0] ir_req;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       inta_n;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic [7:0] irr_out;
  logic [7:0] isr_out;
  logic       freeze;
  modport master (
    output ir_req, imr, vector_base, inta_n, eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
    input  int_out, vector_out, vector_valid, irr_out, isr_out, freeze
  );
  modport slave (
    input  ir_req, imr, vector_base, inta_n, eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
    output int_out, vector_out, vector_valid, irr_out, isr_out, freeze
  );
endinterface

// File: rtl/pic_irq_arbiter_prio_encoder.sv
// pic_prio_encoder: combinational rotating priority encoder.
module pic_prio_encoder
  import pic_pkg::*;
(
  input  logic [7:0]       vec_i,
  input  logic [IDX_W-1:0] lowest_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  assign {found_o, idx_o} = find_first(vec_i, lowest_i);
endmodule

// File: rtl/pic_irq_arbiter.sv
// pic_irq_arbiter: 8259A priority resolver and two-pulse INTA sequencer with ISR/EOI handling.
// Define AUTO_EOI_EN to clear the acknowledged ISR bit automatically at the second INTA edge.
module pic_irq_arbiter
  import pic_pkg::*;
#(
  parameter int NUM_IR       = 8,
  parameter int SPURIOUS_IDX = 7
) (
  input logic              clk,
  input logic              reset_n,
  pic_irq_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  logic [NUM_IR-1:0] irr_q, isr_q, isr_d;
  logic [IDX_W-1:0]  lowest_q, lowest_d, idx_q, idx_d;
  logic              inta_n_q, int_q, int_d, vv_q, vv_d, freeze_q, freeze_d;
  logic [7:0]        vec_q, vec_d;
  logic              req_found, isr_found, cand, fall, eoi_hit;
  logic [IDX_W-1:0]  req_idx, isr_idx, eoi_idx;
`ifdef AUTO_EOI_EN
  logic              hit_q, hit_d;
`endif
  pic_prio_encoder u_req (
    .vec_i   (irr_q & ~bus.imr),
    .lowest_i(lowest_q),
    .found_o (req_found),
    .idx_o   (req_idx)
  );
  pic_prio_encoder u_isr (
    .vec_i   (isr_q),
    .lowest_i(lowest_q),
    .found_o (isr_found),
    .idx_o   (isr_idx)
  );
  assign cand    = req_found && (!isr_found || rank(req_idx, lowest_q) < rank(isr_idx, lowest_q));
  assign fall    = inta_n_q && !bus.inta_n;
  assign eoi_idx = bus.eoi_specific ? bus.eoi_level : isr_idx;
  assign eoi_hit = bus.eoi_valid && (bus.eoi_specific ? isr_q[bus.eoi_level] : isr_found);
  always_comb begin
    state_d  = state_q;
    isr_d    = isr_q;
    lowest_d = lowest_q;
    idx_d    = idx_q;
    int_d    = int_q;
    vv_d     = vv_q;
    freeze_d = freeze_q;
    vec_d    = vec_q;
`ifdef AUTO_EOI_EN
    hit_d    = hit_q;
`endif
    // EOI is applied before any new ISR bit so a same-cycle set always survives.
    if (eoi_hit) begin
      isr_d[eoi_idx] = 1'b0;
      lowest_d = bus.rotate_on_eoi ? eoi_idx : lowest_q;
    end
    case (state_q)
      IDLE: if (cand) begin
        state_d = REQ;
        int_d   = 1'b1;
      end
      REQ: if (fall) begin
        idx_d    = cand ? req_idx : IDX_W'(SPURIOUS_IDX);
        freeze_d = 1'b1;
        state_d  = ACK1;
        if (cand) isr_d[req_idx] = 1'b1;
`ifdef AUTO_EOI_EN
        hit_d    = cand;
`endif
      end else if (!cand) begin
        state_d = IDLE;
        int_d   = 1'b0;
      end
      ACK1: if (fall) begin
        vec_d    = {bus.vector_base, idx_q};
        vv_d     = 1'b1;
        int_d    = 1'b0;
        freeze_d = 1'b0;
        state_d  = ACK2;
`ifdef AUTO_EOI_EN
        if (hit_q) begin
          isr_d[idx_q] = 1'b0;
          lowest_d = bus.rotate_on_eoi ? idx_q : lowest_d;
        end
`endif
      end
      ACK2: if (bus.inta_n) begin
        vv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      irr_q    <= '0;
      isr_q    <= '0;
      lowest_q <= IDX_W'(7);
      idx_q    <= '0;
      inta_n_q <= 1'b1;
      int_q    <= 1'b0;
      vv_q     <= 1'b0;
      freeze_q <= 1'b0;
      vec_q    <= '0;
`ifdef AUTO_EOI_EN
      hit_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      irr_q    <= freeze_q ? irr_q : bus.ir_req;
      isr_q    <= isr_d;
      lowest_q <= lowest_d;
      idx_q    <= idx_d;
      inta_n_q <= bus.inta_n;
      int_q    <= int_d;
      vv_q     <= vv_d;
      freeze_q <= freeze_d;
      vec_q    <= vec_d;
`ifdef AUTO_EOI_EN
      hit_q    <= hit_d;
`endif
    end
  end
  assign bus.int_out      = int_q;
  assign bus.vector_out   = vec_q;
  assign bus.vector_valid = vv_q;
  assign bus.irr_out      = irr_q;
  assign bus.isr_out      = isr_q;
  assign bus.freeze       = freeze_q;
endmodule
